// File: rtl/lcd1602_controller_pkg.sv
// Shared types and constants for the HD44780 16x2 LCD controller and its byte writer.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      INIT     = 3'd1,
      IDLE     = 3'd2,
      ADDR     = 3'd3,
      CHAR     = 3'd4
   } lcd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_EN   = 2'd1,
      WR_GAP  = 2'd2
   } wr_phase_e;

   localparam logic [7:0] FUNC_SET    = 8'h38;
   localparam logic [7:0] DISP_ON     = 8'h0C;
   localparam logic [7:0] CLEAR       = 8'h01;
   localparam logic [7:0] ENTRY       = 8'h06;
   localparam logic [7:0] ROW0        = 8'h80;
   localparam logic [7:0] ROW1        = 8'hC0;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam logic [255:0] BLANK_ROWS = {32{ASCII_SPACE}};

   // Init command issued at each of the four init steps.
   function automatic logic [7:0] init_cmd(input logic [1:0] step);
      logic [7:0] cmd;
      case (step)
         2'd0:    cmd = FUNC_SET;
         2'd1:    cmd = DISP_ON;
         2'd2:    cmd = CLEAR;
         default: cmd = ENTRY;
      endcase
      return cmd;
   endfunction

   // {top,bottom} packs column 0 of row 0 in the top byte, so byte n lives at 255-8n.
   function automatic logic [7:0] row_byte(input logic [255:0] rows,
                                           input logic         row,
                                           input logic [3:0]   col);
      logic [7:0] pos;
      pos = 8'd255 - {row, col, 3'b000};
      return rows[pos -: 8];
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one LCD bus transfer: enable high for EN_CYC, then low for GAP_CYC or CLR_CYC.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int EN_CYC  = 10,
   parameter int GAP_CYC = 500,
   parameter int CLR_CYC = 20000,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   input  logic       long_gap,
   output logic       done,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic [7:0] lcd_data
);

   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);

   wr_phase_e        phase_r;
   logic [CNT_W-1:0] cnt_r;
   logic             en_r;
   logic             rs_r;
   logic [7:0]       data_r;
   logic             long_r;
   logic [CNT_W-1:0] gap_last_s;
   logic             done_s;
   logic             load_s;

   // Gap length and handshake; a new request is taken in the last gap cycle so transfers abut.
   always_comb begin
      if (long_r) begin
         gap_last_s = CLR_LAST;
      end else begin
         gap_last_s = GAP_LAST;
      end
      done_s = (phase_r == WR_GAP) && (cnt_r == gap_last_s);
      load_s = start && ((phase_r == WR_IDLE) || done_s);
   end

   // Transfer phase, timing counter and the latched bus values.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_r <= WR_IDLE;
         cnt_r   <= '0;
         en_r    <= 1'b0;
         rs_r    <= 1'b0;
         data_r  <= 8'h00;
         long_r  <= 1'b0;
      end else if (load_s) begin
         phase_r <= WR_EN;
         cnt_r   <= '0;
         en_r    <= 1'b1;
         rs_r    <= req_rs;
         data_r  <= req_data;
         long_r  <= long_gap;
      end else begin
         case (phase_r)
            WR_EN: begin
               if (cnt_r == EN_LAST) begin
                  en_r    <= 1'b0;
                  phase_r <= WR_GAP;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            WR_GAP: begin
               if (done_s) begin
                  phase_r <= WR_IDLE;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            WR_IDLE: begin
               cnt_r <= '0;
            end
            default: begin
               phase_r <= WR_IDLE;
               cnt_r   <= '0;
               en_r    <= 1'b0;
            end
         endcase
      end
   end

   assign done     = done_s;
   assign lcd_en   = en_r;
   assign lcd_rs   = rs_r;
   assign lcd_data = data_r;

endmodule

// File: rtl/lcd1602_controller.sv
// 16x2 HD44780 sequencer: power-up wait, init commands, then tear-free row rewrites on change or force.
module lcd1602_controller
   import lcd_pkg::*;
#(
   parameter int PWR_CYC = 400000,
   parameter int EN_CYC  = 10,
   parameter int GAP_CYC = 500,
   parameter int CLR_CYC = 20000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] top,
   input  logic [127:0] bottom,
   input  logic         force_req,
   output logic         ready,
   output logic         lcd_en,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic [7:0]   lcd_data
);

   localparam int CNT_W = $clog2(((PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC) + 1);
   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_CYC - 1);

   lcd_state_e       state_r, nxt_state_s;
   logic [1:0]       step_r, nxt_step_s;
   logic             row_r, nxt_row_s;
   logic [3:0]       col_r, nxt_col_s;
   logic [CNT_W-1:0] pwr_cnt_r;
   logic [255:0]     snap_r;
   logic [255:0]     shadow_r;
   logic             ready_r;
   logic [255:0]     rows_s;

   logic             start_s;
   logic             req_rs_s;
   logic [7:0]       req_data_s;
   logic             long_gap_s;
   logic             snap_load_s;
   logic             shadow_init_s;
   logic             shadow_copy_s;
   logic             wr_done_s;

   assign rows_s = {top, bottom};

   // Next state plus the request for the following transfer, raised on the cycle the current one ends.
   always_comb begin
      nxt_state_s   = state_r;
      nxt_step_s    = step_r;
      nxt_row_s     = row_r;
      nxt_col_s     = col_r;
      start_s       = 1'b0;
      req_rs_s      = 1'b0;
      req_data_s    = 8'h00;
      long_gap_s    = 1'b0;
      snap_load_s   = 1'b0;
      shadow_init_s = 1'b0;
      shadow_copy_s = 1'b0;
      case (state_r)
         PWR_WAIT: begin
            if (pwr_cnt_r == PWR_LAST) begin
               nxt_state_s = INIT;
               nxt_step_s  = 2'd0;
               start_s     = 1'b1;
               req_data_s  = init_cmd(2'd0);
            end else begin
               nxt_state_s = PWR_WAIT;
            end
         end
         INIT: begin
            if (!wr_done_s) begin
               nxt_state_s = INIT;
            end else if (step_r == 2'd3) begin
               nxt_state_s   = IDLE;
               shadow_init_s = 1'b1;
            end else begin
               nxt_step_s = step_r + 2'd1;
               start_s    = 1'b1;
               req_data_s = init_cmd(step_r + 2'd1);
               long_gap_s = ((step_r + 2'd1) == 2'd2);
            end
         end
         IDLE: begin
            if (force_req || (rows_s != shadow_r)) begin
               nxt_state_s = ADDR;
               nxt_row_s   = 1'b0;
               snap_load_s = 1'b1;
               start_s     = 1'b1;
               req_data_s  = ROW0;
            end else begin
               nxt_state_s = IDLE;
            end
         end
         ADDR: begin
            if (wr_done_s) begin
               nxt_state_s = CHAR;
               nxt_col_s   = 4'd0;
               start_s     = 1'b1;
               req_rs_s    = 1'b1;
               req_data_s  = row_byte(snap_r, row_r, 4'd0);
            end else begin
               nxt_state_s = ADDR;
            end
         end
         CHAR: begin
            if (!wr_done_s) begin
               nxt_state_s = CHAR;
            end else if (col_r != 4'd15) begin
               nxt_col_s  = col_r + 4'd1;
               start_s    = 1'b1;
               req_rs_s   = 1'b1;
               req_data_s = row_byte(snap_r, row_r, col_r + 4'd1);
            end else if (row_r == 1'b0) begin
               nxt_state_s = ADDR;
               nxt_row_s   = 1'b1;
               start_s     = 1'b1;
               req_data_s  = ROW1;
            end else begin
               nxt_state_s   = IDLE;
               shadow_copy_s = 1'b1;
            end
         end
         default: begin
            nxt_state_s = PWR_WAIT;
         end
      endcase
   end

   // FSM registers, power-up counter and the registered ready flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= PWR_WAIT;
         step_r    <= 2'd0;
         row_r     <= 1'b0;
         col_r     <= 4'd0;
         pwr_cnt_r <= '0;
         ready_r   <= 1'b0;
      end else begin
         state_r <= nxt_state_s;
         step_r  <= nxt_step_s;
         row_r   <= nxt_row_s;
         col_r   <= nxt_col_s;
         ready_r <= (nxt_state_s == IDLE);
         if ((state_r == PWR_WAIT) && (pwr_cnt_r != PWR_LAST)) begin
            pwr_cnt_r <= pwr_cnt_r + CNT_W'(1);
         end else begin
            pwr_cnt_r <= '0;
         end
      end
   end

   // Snapshot freezes the frame being written; shadow remembers what the panel shows.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_r   <= BLANK_ROWS;
         shadow_r <= BLANK_ROWS;
      end else begin
         if (snap_load_s) begin
            snap_r <= rows_s;
         end
         if (shadow_init_s) begin
            shadow_r <= BLANK_ROWS;
         end else if (shadow_copy_s) begin
            shadow_r <= snap_r;
         end
      end
   end

   lcd_byte_writer #(
      .EN_CYC  (EN_CYC),
      .GAP_CYC (GAP_CYC),
      .CLR_CYC (CLR_CYC),
      .CNT_W   (CNT_W)
   ) u_writer (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s),
      .req_rs   (req_rs_s),
      .req_data (req_data_s),
      .long_gap (long_gap_s),
      .done     (wr_done_s),
      .lcd_en   (lcd_en),
      .lcd_rs   (lcd_rs),
      .lcd_data (lcd_data)
   );

   assign lcd_rw = 1'b0;
   assign ready  = ready_r;

endmodule

// File: tb/tb_lcd1602_controller.sv
// Directed bench for lcd1602_controller: expected bus writes are queued at stimulus time and popped on each enable rise.
module tb_lcd1602_controller;

   logic         clk;
   logic         rst;
   logic [127:0] top;
   logic [127:0] bottom;
   logic         force_req;
   logic         ready;
   logic         lcd_en;
   logic         lcd_rs;
   logic         lcd_rw;
   logic [7:0]   lcd_data;

   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           t0;
   int           n_en;
   logic         en_prev = 1'b0;
   logic [8:0]   exp_q[$];
   int           rise_q[$];

   lcd1602_controller #(
      .PWR_CYC (20),
      .EN_CYC  (2),
      .GAP_CYC (4),
      .CLR_CYC (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .top       (top),
      .bottom    (bottom),
      .force_req (force_req),
      .ready     (ready),
      .lcd_en    (lcd_en),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle count since the last edge that sampled reset.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every enable rise must match the oldest queued write.
   always @(negedge clk) begin
      if (lcd_rw !== 1'b0) check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
      if (lcd_en === 1'b1 && en_prev === 1'b0) begin
         rise_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_write: observed rs/data=%0h expected no write", {lcd_rs, lcd_data});
         end else begin
            check("write", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_q.pop_front()});
         end
      end
      en_prev <= lcd_en;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_init();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
   endtask

   task automatic push_rows(input logic [127:0] t, input logic [127:0] b);
      exp_q.push_back({1'b0, 8'h80});
      for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, t[127-8*c -: 8]});
      exp_q.push_back({1'b0, 8'hC0});
      for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, b[127-8*c -: 8]});
   endtask

   task automatic wait_ready(input string tag, input int bound);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $error("FAIL %s: observed ready=%b after %0d cycles, expected 1", tag, ready, bound);
      end
   endtask

   task automatic wait_rise(input string tag, input int bound);
      int n;
      n = 0;
      while (lcd_en !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      if (lcd_en !== 1'b1) begin
         checks++;
         errors++;
         $error("FAIL %s: observed lcd_en=%b after %0d cycles, expected 1", tag, lcd_en, bound);
      end
   endtask

   initial begin
      rst       = 1'b1;
      top       = {16{8'h20}};
      bottom    = {16{8'h20}};
      force_req = 1'b0;
      repeat (3) tick();
      check("rst_en",    {31'd0, lcd_en}, 32'd0);
      check("rst_rs",    {31'd0, lcd_rs}, 32'd0);
      check("rst_rw",    {31'd0, lcd_rw}, 32'd0);
      check("rst_data",  {24'd0, lcd_data}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);

      // Power-up and init
      push_init();
      rise_q.delete();
      rst = 1'b0;
      wait_rise("init_rise", 100);
      check("first_rise_cyc", cyc, 32'd20);
      wait_ready("init_ready", 200);
      check("init_ready_cyc", cyc, 32'd50);
      check("clear_gap", rise_q[3] - rise_q[2], 32'd12);
      check("init_q_empty", exp_q.size(), 32'd0);

      // Content-change refresh
      top = "  HANGMAN       ";
      push_rows(top, bottom);
      t0 = cyc + 1;
      tick();
      check("hang_ready_fall", {31'd0, ready}, 32'd0);
      check("hang_en_rise", {31'd0, lcd_en}, 32'd1);
      wait_ready("hang_ready", 400);
      check("hang_duration", cyc - t0, 32'd204);
      check("hang_q_empty", exp_q.size(), 32'd0);

      // Force in IDLE, then a force while busy that must be dropped
      force_req = 1'b1;
      push_rows(top, bottom);
      t0 = cyc + 1;
      tick();
      force_req = 1'b0;
      check("force_ready_fall", {31'd0, ready}, 32'd0);
      repeat (30) tick();
      force_req = 1'b1;
      tick();
      force_req = 1'b0;
      wait_ready("force_ready", 400);
      check("force_duration", cyc - t0, 32'd204);
      repeat (200) tick();
      check("force_q_empty", exp_q.size(), 32'd0);

      // Input change mid-refresh is written by an immediate follow-up refresh
      force_req = 1'b1;
      push_rows(top, bottom);
      t0 = cyc + 1;
      tick();
      force_req = 1'b0;
      repeat (50) tick();
      bottom[7:0] = 8'h57;
      push_rows(top, bottom);
      wait_ready("mid_ready1", 400);
      check("mid_duration1", cyc - t0, 32'd204);
      tick();
      check("mid_retrigger_ready", {31'd0, ready}, 32'd0);
      check("mid_retrigger_en", {31'd0, lcd_en}, 32'd1);
      t0 = cyc;
      wait_ready("mid_ready2", 400);
      check("mid_duration2", cyc - t0, 32'd204);
      check("mid_q_empty", exp_q.size(), 32'd0);

      // Quiet period with constant inputs
      n_en = 0;
      repeat (1000) begin
         tick();
         if (lcd_en !== 1'b0) n_en++;
      end
      check("quiet_en_cycles", n_en, 32'd0);

      // Reset in the middle of a character transfer
      top = "HELLO WORLD!    ";
      exp_q.push_back({1'b0, 8'h80});
      exp_q.push_back({1'b1, 8'h48});
      tick();
      repeat (7) tick();
      check("char_in_flight", {30'd0, lcd_en, lcd_rs}, 32'd3);
      rst = 1'b1;
      tick();
      check("midrst_en", {31'd0, lcd_en}, 32'd0);
      check("midrst_ready", {31'd0, ready}, 32'd0);
      tick();
      check("midrst_q_empty", exp_q.size(), 32'd0);
      push_init();
      push_rows(top, bottom);
      rise_q.delete();
      rst = 1'b0;
      wait_rise("reinit_rise", 100);
      check("reinit_first_rise", cyc, 32'd20);
      wait_ready("reinit_ready", 200);
      check("reinit_ready_cyc", cyc, 32'd50);
      tick();
      check("reinit_refresh_start", {31'd0, ready}, 32'd0);
      wait_ready("reinit_refresh", 400);
      check("reinit_q_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lcd1602_controller.md
# lcd1602_controller

Sequences a 16x2 HD44780-compatible character LCD (8-bit bus, write-only) from the two 128-bit ASCII row buffers the host display logic produces. It performs the power-on initialisation, then rewrites both rows whenever their contents change or a refresh is forced. It snapshots the rows at the start of each refresh so the panel never shows a torn frame. It sits between the host display block and the board LCD pins.

## Interface

Parameters:
- PWR_CYC, 400000: cycles to wait after reset before the first command (power-up settle).
- EN_CYC, 10: cycles lcd_en is held high per transfer.
- GAP_CYC, 500: cycles lcd_en is held low after each transfer (command/data execution time).
- CLR_CYC, 20000: low-gap cycles used instead of GAP_CYC after the clear command only.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- top, in, 128: row 0 ASCII; [127:120] = column 0 (leftmost), [7:0] = column 15.
- bottom, in, 128: row 1 ASCII, same byte order.
- force, in, 1: single-cycle request to rewrite both rows even if unchanged.
- ready, out, 1: high only in IDLE (init done, no refresh in progress).
- lcd_en, out, 1: LCD enable strobe.
- lcd_rs, out, 1: 0 = command, 1 = data.
- lcd_rw, out, 1: constant 0.
- lcd_data, out, 8: LCD data bus.

## Operation

- States: PWR_WAIT, INIT, IDLE, ADDR, CHAR.
- PWR_WAIT: count PWR_CYC cycles, then go to INIT.
- INIT: issue four commands in order: 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x01 (clear, followed by a CLR_CYC gap), 0x06 (increment, no shift). Then go to IDLE with the shadow buffers set to 32 spaces (0x20).
- IDLE: a refresh starts when force=1, or when {top,bottom} differs from the shadow (last-written) buffers. On start, latch {top,bottom} into the snapshot registers. Go to ADDR with row=0.
- ADDR: send command 0x80 (row 0) or 0xC0 (row 1), then go to CHAR with col=0.
- CHAR: send snapshot byte [row][col] with rs=1. Increment col. After col 15: if row=0, set row=1 and go to ADDR; else copy the snapshot into the shadow and go to IDLE.
- Each transfer: lcd_rs and lcd_data become valid on the same cycle lcd_en rises. lcd_en stays high for EN_CYC cycles, then low for GAP_CYC (or CLR_CYC) cycles. rs and data are held stable through the whole transfer.
- Input changes during a refresh are ignored until IDLE is reached. The shadow comparison then triggers another refresh, so no update is lost. A force pulse arriving outside IDLE is dropped.
- force and a content change in the same cycle produce one refresh.
- rst at any time, including mid-transfer or mid-refresh: return to PWR_WAIT and redo the full init.

## Timing

- Reset values: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, ready=0. State=PWR_WAIT, counters=0, shadow and snapshot=0x20 per byte.
- First lcd_en rise occurs PWR_CYC cycles after reset deasserts.
- Init duration: 4*EN_CYC + 3*GAP_CYC + CLR_CYC cycles. ready rises on the cycle after the last gap ends.
- Refresh latency: ready falls and lcd_en rises 1 cycle after the triggering condition is sampled in IDLE.
- Refresh duration: 34*(EN_CYC+GAP_CYC) cycles. ready rises the cycle after the last gap ends.
- Delay counters are wide enough for the largest of PWR_CYC and CLR_CYC (use $clog2). Counters never wrap.

## Structure

- Shared package lcd_pkg holds: the state enum, the command constants (FUNC_SET=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY=0x06, ROW0=0x80, ROW1=0xC0), and ASCII_SPACE=0x20.
- One sub-module, lcd_byte_writer: it accepts a start/rs/byte/long_gap request and generates the en strobe and EN/GAP/CLR timing, returning done. It is instantiated once. The controller FSM only chooses the byte to send and the next state.

## Test plan

Run with PWR_CYC=20, EN_CYC=2, GAP_CYC=4, CLR_CYC=10.

- Reset release → first en rise at cycle 20. Bytes seen are 0x38, 0x0C, 0x01, 0x06 with rs=0. Gap after 0x01 is 10 cycles. ready=1 at cycle 20+8+12+10.
- top="  HANGMAN       ", bottom all spaces → sequence 0x80, 16 top bytes with rs=1, 0xC0, 16 bottom bytes. Duration 204 cycles, then ready=1 and no further activity.
- Change bottom[7:0] to "W" mid-refresh → the current refresh completes with the old snapshot byte. A second full refresh follows immediately and writes "W" as its last byte.
- force pulse in IDLE with unchanged inputs → exactly one refresh. A force pulse while ready=0 → no extra refresh.
- Assert rst during a CHAR transfer → lcd_en=0 and ready=0 on the next cycle. Full init repeats from PWR_WAIT.
- Hold inputs constant for 1000 cycles after a refresh → lcd_en stays 0 throughout. lcd_rw is 0 on every cycle of the test.
